// File: rtl/data_array_rd_pipe.sv
// Read-side controller for the 256x256 banked data array: issues tagged reads on R0, buffers
// returned lines in a credit-managed response FIFO. Optional perf counters: DATA_ARRAY_RD_PERF_EN.
module data_array_rd_pipe #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              R0_en,
    output logic [ADDR_W-1:0] R0_addr,
    input  logic [DATA_W-1:0] R0_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef DATA_ARRAY_RD_PERF_EN
    ,
    output logic [31:0]       perf_reads,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rsp_entry_t;

    rsp_entry_t        fifo_mem [DEPTH];
    logic              inflight;
    logic [TAG_W-1:0]  inflight_tag;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fire;
    logic              pop;
    logic              push;
    logic [OCC_W-1:0]  occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A credit covers both the read in flight and the buffered lines; a same-cycle pop frees one.
    always_comb begin
        rsp_valid = (count != '0);
        pop       = rsp_valid & rsp_ready;
        push      = inflight;
        occ       = OCC_W'(inflight) + OCC_W'(count) - OCC_W'(pop);
        req_ready = (occ < OCC_W'(DEPTH)) & ~reset;
        fire      = req_valid & req_ready;
        R0_en     = fire;
        R0_addr   = req_addr;
        rsp_data  = fifo_mem[rd_ptr].data;
        rsp_tag   = fifo_mem[rd_ptr].tag;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= fire;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Capture runs unconditionally on push: the credit check guarantees a free slot.
    always_ff @(posedge clock) begin
        if (fire) inflight_tag <= req_tag;
        if (push) fifo_mem[wr_ptr] <= '{tag: inflight_tag, data: R0_data};
    end

`ifdef DATA_ARRAY_RD_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_reads <= '0;
            perf_stall <= '0;
        end else begin
            if (fire && (perf_reads != 32'hFFFF_FFFF)) perf_reads <= perf_reads + 32'd1;
            if (rsp_valid && !rsp_ready && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

    occupancy_bound: assert property (@(posedge clock) disable iff (reset)
        (OCC_W'(inflight) + OCC_W'(count)) <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_data_array_rd_pipe.sv
// Bench for data_array_rd_pipe: array model, vector table, corner sequences and a randomized
// run against an in-order transaction model. Perf checks compile in with DATA_ARRAY_RD_PERF_EN.
module tb_data_array_rd_pipe;

    localparam int DEPTH = 2;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_addr;
    logic [5:0]   req_tag;
    logic         R0_en;
    logic [7:0]   R0_addr;
    logic [255:0] R0_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_data;
    logic [5:0]   rsp_tag;
`ifdef DATA_ARRAY_RD_PERF_EN
    logic [31:0]  perf_reads;
    logic [31:0]  perf_stall;
`endif

    // Array write port driven by the bench
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [1:0]   wr_mask;
    logic [255:0] wr_data;
    logic [255:0] mem [256];

    int vectors;
    int miscompares;
    int cyc;
    int exp_reads;
    int exp_stall;

    typedef struct {
        logic [255:0] data;
        logic [5:0]   tag;
        int           ready_cyc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic       rv;
        logic [7:0] a;
        logic [5:0] t;
        logic       rr;
        logic       e_rdy;
        logic       e_en;
        logic       e_rv;
        logic [5:0] e_tag;
        logic [7:0] e_addr;
    } vec_t;
    vec_t tbl [12];

    data_array_rd_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_tag   (req_tag),
        .R0_en     (R0_en),
        .R0_addr   (R0_addr),
        .R0_data   (R0_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag)
`ifdef DATA_ARRAY_RD_PERF_EN
        ,
        .perf_reads(perf_reads),
        .perf_stall(perf_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [1:0] m,
                                           input logic [255:0] d);
        logic [255:0] r;
        r = old;
        if (m[0]) r[127:0]   = d[127:0];
        if (m[1]) r[255:128] = d[255:128];
        return r;
    endfunction

    // Write-first synchronous-read array
    initial R0_data = '0;
    always @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= merge(mem[wr_addr], wr_mask, wr_data);
        if (R0_en) R0_data <= (wr_en && wr_addr == R0_addr) ?
                              merge(mem[R0_addr], wr_mask, wr_data) : mem[R0_addr];
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then at the falling edge check against the transaction model.
    task automatic apply(input logic rv, input logic [7:0] a, input logic [5:0] t, input logic rr,
                         input logic we, input logic [7:0] wa, input logic [1:0] wm,
                         input logic [255:0] wd);
        logic e_rv, e_pop, e_rdy, e_fire;
        logic [255:0] line;
        exp_t e;
        req_valid = rv; req_addr = a; req_tag = t; rsp_ready = rr;
        wr_en = we; wr_addr = wa; wr_mask = wm; wr_data = wd;
        @(negedge clock);
        e_rv   = (q.size() > 0) && (cyc >= q[0].ready_cyc);
        e_pop  = e_rv && rr;
        e_rdy  = (q.size() - (e_pop ? 1 : 0)) < DEPTH;
        e_fire = rv && e_rdy;
        chk("req_ready", 256'(req_ready), 256'(e_rdy));
        chk("R0_en", 256'(R0_en), 256'(e_fire));
        if (e_fire) chk("R0_addr", 256'(R0_addr), 256'(a));
        chk("rsp_valid", 256'(rsp_valid), 256'(e_rv));
        if (e_rv) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_tag", 256'(rsp_tag), 256'(q[0].tag));
        end
        if (e_pop) void'(q.pop_front());
        if (e_fire) begin
            line = mem[a];
            if (we && wa == a) line = merge(line, wm, wd);
            e.data = line; e.tag = t; e.ready_cyc = cyc + 2;
            q.push_back(e);
            exp_reads++;
        end
        if (e_rv && !rr) exp_stall++;
        cyc++;
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic rr);
        apply(1'b0, 8'd0, 6'd0, rr, 1'b0, 8'd0, 2'b00, '0);
    endtask

    initial begin
        logic [255:0] old7;
        logic [255:0] exp7;
        vectors = 0; miscompares = 0; cyc = 0; exp_reads = 0; exp_stall = 0;
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;

        tbl[0]  = '{1'b1, 8'd5,  6'd3,  1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  8'd0};
        tbl[1]  = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  8'd0};
        tbl[2]  = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b1, 1'b0, 1'b1, 6'd3,  8'd5};
        tbl[3]  = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  8'd0};
        tbl[4]  = '{1'b1, 8'd20, 6'd10, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  8'd0};
        tbl[5]  = '{1'b1, 8'd21, 6'd11, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  8'd0};
        tbl[6]  = '{1'b1, 8'd22, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 8'd20};
        tbl[7]  = '{1'b1, 8'd22, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 8'd20};
        tbl[8]  = '{1'b1, 8'd22, 6'd12, 1'b1, 1'b1, 1'b1, 1'b1, 6'd10, 8'd20};
        tbl[9]  = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b1, 1'b0, 1'b1, 6'd11, 8'd21};
        tbl[10] = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b1, 1'b0, 1'b1, 6'd12, 8'd22};
        tbl[11] = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  8'd0};

        // Reset state with a request pending
        #1 reset = 1'b1;
        req_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("reset_req_ready", 256'(req_ready), 256'(1'b0));
        chk("reset_R0_en", 256'(R0_en), 256'(1'b0));
        chk("reset_rsp_valid", 256'(rsp_valid), 256'(1'b0));
        req_valid = 1'b0;

        // Preload array while reset holds the pipe idle
        next_edge();
        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_mask = 2'b11;
            wr_data = (i == 5) ? {128'hA, 128'hB}
                               : {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom};
            next_edge();
        end
        wr_en = 1'b0;
        reset = 1'b0;

        // Single read and backpressure vectors
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].rv, tbl[i].a, tbl[i].t, tbl[i].rr, 1'b0, 8'd0, 2'b00, '0);
            chk("tbl_req_ready", 256'(req_ready), 256'(tbl[i].e_rdy));
            chk("tbl_R0_en", 256'(R0_en), 256'(tbl[i].e_en));
            if (tbl[i].e_en) chk("tbl_R0_addr", 256'(R0_addr), 256'(tbl[i].a));
            chk("tbl_rsp_valid", 256'(rsp_valid), 256'(tbl[i].e_rv));
            if (tbl[i].e_rv) begin
                chk("tbl_rsp_tag", 256'(rsp_tag), 256'(tbl[i].e_tag));
                chk("tbl_rsp_data", rsp_data, mem[tbl[i].e_addr]);
            end
            next_edge();
        end

        // Streaming: 16 back-to-back reads with the consumer always ready
        for (int k = 0; k < 18; k++) begin
            apply(k < 16, 8'(k), 6'(k), 1'b1, 1'b0, 8'd0, 2'b00, '0);
            if (k < 16) chk("stream_req_ready", 256'(req_ready), 256'(1'b1));
            if (k >= 2) begin
                chk("stream_rsp_valid", 256'(rsp_valid), 256'(1'b1));
                chk("stream_rsp_tag", 256'(rsp_tag), 256'(k - 2));
            end
            next_edge();
        end

        // Write-first on the issue edge, then a later write must not disturb the buffered line
        old7 = mem[7];
        exp7 = {old7[255:128], 128'hC};
        apply(1'b1, 8'd7, 6'd5, 1'b0, 1'b1, 8'd7, 2'b01, {128'h0, 128'hC});
        next_edge();
        idle(1'b0);
        next_edge();
        apply(1'b0, 8'd0, 6'd0, 1'b0, 1'b1, 8'd7, 2'b10, {128'hDEAD_BEEF, 128'h0});
        chk("wf_rsp_valid", 256'(rsp_valid), 256'(1'b1));
        chk("wf_rsp_data", rsp_data, exp7);
        next_edge();
        idle(1'b1);
        chk("wf_rsp_data_after_write", rsp_data, exp7);
        chk("wf_rsp_tag", 256'(rsp_tag), 256'(6'd5));
        next_edge();
        idle(1'b1);
        next_edge();

        // Asynchronous reset with one read in flight and one buffered
        apply(1'b1, 8'd20, 6'd1, 1'b0, 1'b0, 8'd0, 2'b00, '0);
        next_edge();
        apply(1'b1, 8'd21, 6'd2, 1'b0, 1'b0, 8'd0, 2'b00, '0);
        next_edge();
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rsp_valid", 256'(rsp_valid), 256'(1'b0));
        chk("async_req_ready", 256'(req_ready), 256'(1'b0));
        q.delete();
        exp_reads = 0; exp_stall = 0;
        @(posedge clock);
        #3 reset = 1'b0;
        next_edge();
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk("post_reset_no_rsp", 256'(rsp_valid), 256'(1'b0));
            next_edge();
        end
        apply(1'b1, 8'd9, 6'd33, 1'b1, 1'b0, 8'd0, 2'b00, '0);
        next_edge();
        idle(1'b1);
        chk("post_reset_lat1", 256'(rsp_valid), 256'(1'b0));
        next_edge();
        idle(1'b1);
        chk("post_reset_lat2", 256'(rsp_valid), 256'(1'b1));
        chk("post_reset_tag", 256'(rsp_tag), 256'(6'd33));
        chk("post_reset_data", rsp_data, mem[9]);
        next_edge();

        // Randomized traffic against the transaction model
        for (int k = 0; k < 400; k++) begin
            apply($urandom_range(0, 3) != 0, 8'($urandom), 6'($urandom), $urandom_range(0, 2) != 0,
                  1'b0, 8'd0, 2'b00, '0);
            next_edge();
        end
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            next_edge();
        end

`ifdef DATA_ARRAY_RD_PERF_EN
        chk("perf_reads", 256'(perf_reads), 256'(exp_reads));
        chk("perf_stall", 256'(perf_stall), 256'(exp_stall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
